mem_stage_pipelined: RTL

//  Parametrised MIPS MEM stage with multi-cycle data-RAM access, byte/half/word loads and stores,
//  BEQ/BNE branch resolution and a registered MEM/WB pipeline register.

---
 rtl/mem_stage_pkg.sv | 31 +++
 rtl/mem_stage_ram.sv | 30 +++
 rtl/mem_stage_pipelined.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MIPS MEM stage: access sizes, FSM states and lane helpers.
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Lane actually used once the address is rounded down to the access size.
    function automatic logic [1:0] eff_lane(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            SZ_BYTE: eff_lane = lane;
            SZ_HALF: eff_lane = {lane[1], 1'b0};
            default: eff_lane = 2'b00;
        endcase
    endfunction

    // Reserved size 2'b11 behaves as a word.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = lane[0];
            default: is_misaligned = (lane != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_ram.sv
// Word-organised data RAM with per-byte write enables and a combinational read; never reset.
module mem_stage_ram #(
    parameter int unsigned NBITS     = 32,
    parameter int unsigned MEM_DEPTH = 256,
    localparam int unsigned AW       = $clog2(MEM_DEPTH),
    localparam int unsigned NBYTES   = NBITS / 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [NBYTES-1:0] i_be,
    input  logic [AW-1:0]     i_addr,
    input  logic [NBITS-1:0]  i_wdata,
    output logic [NBITS-1:0]  o_rdata
);

    logic [NBITS-1:0] r_mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage_pipelined.sv
// MIPS MEM stage: multi-cycle RAM access, sub-word loads/stores, BEQ/BNE resolution, MEM/WB register.
// Optional alignment fault reporting is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage_pipelined
    import mem_stage_pkg::*;
#(
    parameter int unsigned      NBITS       = 32,
    parameter logic [NBITS-1:0] DATA_BASE   = 32'h1001_0000,
    parameter int unsigned      MEM_DEPTH   = 256,
    parameter int unsigned      MEM_LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [1:0]       size,
    input  logic             load_unsigned,
    input  logic             zero,
    input  logic             branch_eq,
    input  logic             branch_ne,
    input  logic [NBITS-1:0] alu_result,
    input  logic [NBITS-1:0] write_data,
    input  logic [NBITS-1:0] pc_plus4,
    input  logic [NBITS-1:0] branch_addr,
    input  logic             reg_write_in,
    input  logic             mem_to_reg_in,
    input  logic [4:0]       write_reg_in,
    output logic             stall,
    output logic             branch_taken,
    output logic [NBITS-1:0] pc_next,
    output logic             wb_valid,
    output logic [NBITS-1:0] wb_mem_data,
    output logic [NBITS-1:0] wb_alu_result,
    output logic [4:0]       wb_write_reg,
    output logic             wb_reg_write,
    output logic             wb_mem_to_reg,
    output logic             addr_fault
);

    localparam int unsigned AW       = $clog2(MEM_DEPTH);
    localparam int unsigned NBYTES   = NBITS / 8;
    localparam logic [2:0]  CNT_LAST = (MEM_LATENCY > 0) ? 3'(MEM_LATENCY - 1) : 3'd0;

    function automatic logic [NBITS-1:0] load_extend(input logic [NBITS-1:0] sh,
                                                     input logic [1:0] sz,
                                                     input logic uns);
        case (sz)
            SZ_BYTE: load_extend = uns ? {{(NBITS-8){1'b0}}, sh[7:0]}
                                       : {{(NBITS-8){sh[7]}}, sh[7:0]};
            SZ_HALF: load_extend = uns ? {{(NBITS-16){1'b0}}, sh[15:0]}
                                       : {{(NBITS-16){sh[15]}}, sh[15:0]};
            default: load_extend = sh;
        endcase
    endfunction

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_cnt, w_cnt_nxt;
    logic              w_stall;
    logic              w_done;

    logic [NBITS-1:0]  w_offset;
    logic              w_in_range;
    logic [AW-1:0]     w_widx;
    logic [1:0]        w_lane;
    logic [1:0]        w_lane_eff;
    logic              w_is_mem;
    logic              w_is_store;
    logic              w_is_load;
    logic              w_fault;
    logic              w_we;
    logic [NBYTES-1:0] w_be;
    logic [NBITS-1:0]  w_wdata;
    logic [NBITS-1:0]  w_rdata;
    logic [NBITS-1:0]  w_rshift;
    logic [NBITS-1:0]  w_load_val;

    logic              r_wb_valid;
    logic [NBITS-1:0]  r_wb_mem_data;
    logic [NBITS-1:0]  r_wb_alu_result;
    logic [4:0]        r_wb_write_reg;
    logic              r_wb_reg_write;
    logic              r_wb_mem_to_reg;

    assign branch_taken = in_valid & ((branch_eq & zero) | (branch_ne & ~zero));
    assign pc_next      = branch_taken ? branch_addr : pc_plus4;

    // Addresses below DATA_BASE wrap to huge offsets and fall out of range too.
    assign w_offset   = alu_result - DATA_BASE;
    assign w_in_range = (w_offset[NBITS-1:AW+2] == '0);
    assign w_widx     = w_offset[AW+1:2];
    assign w_lane     = w_offset[1:0];
    assign w_lane_eff = eff_lane(size, w_lane);

    assign w_is_mem   = in_valid & (mem_read | mem_write);
    assign w_is_store = in_valid & mem_write;
    assign w_is_load  = in_valid & mem_read & ~mem_write;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_fault = w_is_mem & is_misaligned(size, w_lane);
`else
    assign w_fault = 1'b0;
`endif

    always_comb begin
        case (size)
            SZ_BYTE: w_be = {{(NBYTES-1){1'b0}}, 1'b1} << w_lane_eff;
            SZ_HALF: w_be = {{(NBYTES-2){1'b0}}, 2'b11} << w_lane_eff;
            default: w_be = '1;
        endcase
    end

    always_comb begin
        case (size)
            SZ_BYTE: w_wdata = {NBYTES{write_data[7:0]}};
            SZ_HALF: w_wdata = {(NBITS/16){write_data[15:0]}};
            default: w_wdata = write_data;
        endcase
    end

    // Gating with reset keeps an aborted store from landing on the edge reset is low.
    assign w_we = w_done & w_is_store & w_in_range & ~w_fault & reset;

    mem_stage_ram #(
        .NBITS     (NBITS),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (w_widx),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    assign w_rshift   = w_rdata >> {w_lane_eff, 3'b000};
    assign w_load_val = (w_is_load & w_in_range) ? load_extend(w_rshift, size, load_unsigned) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_is_mem) begin
                    if (MEM_LATENCY == 0) begin
                        w_done = 1'b1;
                    end else begin
                        w_state_nxt = ST_ACCESS;
                        w_cnt_nxt   = 3'd0;
                        w_stall     = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 3'd0;
                    w_done      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                    w_stall   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    assign stall = w_stall;

    // MEM/WB register: a stalled slot is passed on as a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_valid      <= 1'b0;
            r_wb_mem_data   <= '0;
            r_wb_alu_result <= '0;
            r_wb_write_reg  <= 5'd0;
            r_wb_reg_write  <= 1'b0;
            r_wb_mem_to_reg <= 1'b0;
        end else if (w_stall) begin
            r_wb_valid <= 1'b0;
        end else begin
            r_wb_valid <= in_valid;
            if (in_valid) begin
                r_wb_mem_data   <= w_load_val;
                r_wb_alu_result <= alu_result;
                r_wb_write_reg  <= write_reg_in;
                r_wb_reg_write  <= reg_write_in & ~w_fault;
                r_wb_mem_to_reg <= mem_to_reg_in;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic r_addr_fault;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr_fault <= 1'b0;
        end else if (!w_stall && in_valid) begin
            r_addr_fault <= w_fault;
        end
    end

    assign addr_fault = r_addr_fault;
`else
    assign addr_fault = 1'b0;
`endif

    assign wb_valid      = r_wb_valid;
    assign wb_mem_data   = r_wb_mem_data;
    assign wb_alu_result = r_wb_alu_result;
    assign wb_write_reg  = r_wb_write_reg;
    assign wb_reg_write  = r_wb_reg_write;
    assign wb_mem_to_reg = r_wb_mem_to_reg;

endmodule
